writeback_regfile: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline register: selects the writeback value, commits it to the 32-entry integer register file, and serves the two ID-stage read ports.
- Sits between MEM/WB outputs and ID-stage operand fetch.
- Provides same-cycle write-to-read bypass, a combinational writeback value for the forwarding unit, and a retired-write counter for debug/performance.

---
 rtl/writeback_regfile.sv | 63 ++++++
 tb/tb_writeback_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - MEM/WB writeback mux, 32-entry register file with write-through bypass, retire counter
module writeback_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] Memdata_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic              WBvalid_o,
    output logic [CNT_W-1:0]  RetireCnt_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  retire_cnt;

    assign WBdata_o    = MemtoReg_i ? Memdata_i : ALUResult_i;
    assign WBvalid_o   = RegWrite_i && (RDaddr_i != '0);
    assign RetireCnt_o = retire_cnt;

    // x0 is never stored because WBvalid_o is low whenever RDaddr_i is zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            retire_cnt <= '0;
        end else if (WBvalid_o) begin
            regs[RDaddr_i] <= WBdata_o;
            retire_cnt     <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Same-cycle bypass lets ID see the value being retired this edge.
    always_comb begin
        RS1data_o = regs[RS1addr_i];
        if (RS1addr_i == '0) begin
            RS1data_o = '0;
        end else if (WBvalid_o && (RS1addr_i == RDaddr_i)) begin
            RS1data_o = WBdata_o;
        end
    end

    always_comb begin
        RS2data_o = regs[RS2addr_i];
        if (RS2addr_i == '0) begin
            RS2data_o = '0;
        end else if (WBvalid_o && (RS2addr_i == RDaddr_i)) begin
            RS2data_o = WBdata_o;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] retire_cnt;

    logic [31:0] rs1_data_n;
    logic [31:0] rs2_data_n;
    logic [31:0] wb_data_n;
    logic        wb_valid_n;
    logic [3:0]  retire_cnt_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .RegWrite_i  (reg_write),
        .MemtoReg_i  (mem_to_reg),
        .Memdata_i   (mem_data),
        .ALUResult_i (alu_result),
        .RDaddr_i    (rd_addr),
        .RS1addr_i   (rs1_addr),
        .RS2addr_i   (rs2_addr),
        .RS1data_o   (rs1_data),
        .RS2data_o   (rs2_data),
        .WBdata_o    (wb_data),
        .WBvalid_o   (wb_valid),
        .RetireCnt_o (retire_cnt)
    );

    writeback_regfile #(.CNT_W(4)) dut_narrow (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .RegWrite_i  (reg_write),
        .MemtoReg_i  (mem_to_reg),
        .Memdata_i   (mem_data),
        .ALUResult_i (alu_result),
        .RDaddr_i    (rd_addr),
        .RS1addr_i   (rs1_addr),
        .RS2addr_i   (rs2_addr),
        .RS1data_o   (rs1_data_n),
        .RS2data_o   (rs2_data_n),
        .WBdata_o    (wb_data_n),
        .WBvalid_o   (wb_valid_n),
        .RetireCnt_o (retire_cnt_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_data   = 32'h0;
        alu_result = 32'h0;
        rd_addr    = 5'd0;
        rs1_addr   = 5'd5;
        rs2_addr   = 5'd7;
        #1;
        chk("reset_rs1_x5", rs1_data, 0);
        chk("reset_rs2_x7", rs2_data, 0);
        chk("reset_cnt", retire_cnt, 0);

        // ALU-path commit to x7
        @(negedge clk);
        rst_n      = 1'b1;
        reg_write  = 1'b1;
        alu_result = 32'hDEADBEEF;
        rd_addr    = 5'd7;
        rs1_addr   = 5'd0;
        #1;
        chk("alu_wbvalid", wb_valid, 1);
        chk("alu_wbdata", wb_data, 32'hDEADBEEF);
        chk("alu_bypass_rs2", rs2_data, 32'hDEADBEEF);
        chk("alu_rs1_x0", rs1_data, 0);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        chk("alu_stored_x7", rs2_data, 32'hDEADBEEF);
        chk("alu_cnt", retire_cnt, 1);

        // load-path commit to x3 with both ports bypassing
        @(negedge clk);
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        mem_data   = 32'hCAFEF00D;
        alu_result = 32'h55;
        rd_addr    = 5'd3;
        rs1_addr   = 5'd3;
        rs2_addr   = 5'd3;
        #1;
        chk("load_wbvalid", wb_valid, 1);
        chk("load_wbdata", wb_data, 32'hCAFEF00D);
        chk("load_bypass_rs1", rs1_data, 32'hCAFEF00D);
        chk("load_bypass_rs2", rs2_data, 32'hCAFEF00D);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        chk("load_stored_rs1", rs1_data, 32'hCAFEF00D);
        chk("load_stored_rs2", rs2_data, 32'hCAFEF00D);
        chk("load_cnt", retire_cnt, 2);

        // write to x0 is dropped
        @(negedge clk);
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        alu_result = 32'hFFFFFFFF;
        rd_addr    = 5'd0;
        rs1_addr   = 5'd0;
        #1;
        chk("x0_wbvalid", wb_valid, 0);
        chk("x0_wbdata", wb_data, 32'hFFFFFFFF);
        chk("x0_rs1_before", rs1_data, 0);
        @(negedge clk);
        #1;
        chk("x0_rs1_after", rs1_data, 0);
        chk("x0_cnt", retire_cnt, 2);

        // prime x9 = 0x11, then present a disabled write of 0x22
        @(negedge clk);
        alu_result = 32'h11;
        rd_addr    = 5'd9;
        rs1_addr   = 5'd9;
        @(negedge clk);
        reg_write  = 1'b0;
        alu_result = 32'h22;
        #1;
        chk("dis_cnt_primed", retire_cnt, 3);
        chk("dis_wbvalid", wb_valid, 0);
        chk("dis_wbdata", wb_data, 32'h22);
        chk("dis_no_bypass", rs1_data, 32'h11);
        @(negedge clk);
        #1;
        chk("dis_x9_kept", rs1_data, 32'h11);
        chk("dis_cnt", retire_cnt, 3);

        // write x5 = 0x1234, then reset asynchronously between edges
        @(negedge clk);
        reg_write  = 1'b1;
        alu_result = 32'h1234;
        rd_addr    = 5'd5;
        rs1_addr   = 5'd5;
        rs2_addr   = 5'd7;
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        chk("rst_pre_x5", rs1_data, 32'h1234);
        chk("rst_pre_cnt", retire_cnt, 4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_x5", rs1_data, 0);
        chk("rst_async_x7", rs2_data, 0);
        chk("rst_async_cnt", retire_cnt, 0);
        chk("rst_async_cnt4", retire_cnt_n, 0);

        // write presented while reset is held must be discarded
        @(negedge clk);
        reg_write  = 1'b1;
        alu_result = 32'h77;
        rd_addr    = 5'd6;
        rs2_addr   = 5'd6;
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        chk("rst_hold_x6", rs2_data, 0);
        chk("rst_hold_cnt", retire_cnt, 0);

        // 17 valid writes: 4-bit counter runs 1..15, 0, 1
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            reg_write  = 1'b1;
            alu_result = 32'(i);
            rd_addr    = 5'((i % 31) + 1);
            @(negedge clk);
            #1;
            chk($sformatf("wrap_cnt4_%0d", i), retire_cnt_n, 64'(i % 16));
        end
        reg_write = 1'b0;
        rs1_addr  = 5'd17;
        #1;
        chk("wrap_cnt32", retire_cnt, 17);
        chk("wrap_x17", rs1_data, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
